// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync generator with an internal pixel-clock-enable divider.
// Ports:
//   clk_i          system clock
//   reset_i        synchronous active-high reset
//   enable_i       run enable; low freezes all counters
//   pixel_tick_o   one-clk pixel enable, once per CLK_DIV clocks
//   hsync_o        horizontal sync, active level H_POL
//   vsync_o        vertical sync, active level V_POL
//   video_on_o     high inside the visible area
//   pixel_x_o      horizontal position (XW bits)
//   pixel_y_o      vertical position (YW bits)
//   line_start_o   one-clk pulse after h wraps to 0
//   frame_start_o  one-clk pulse after h and v both wrap to 0
//   frame_cnt_o    8-bit frame counter, only with VGA_FRAME_COUNTER_EN defined
// All outputs are registered and decoded from next-state counts, so the
// sync/video/strobe outputs line up with pixel_x_o/pixel_y_o.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CLK_DIV  = 4,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          enable_i,
  output logic          pixel_tick_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          video_on_o,
  output logic [XW-1:0] pixel_x_o,
  output logic [YW-1:0] pixel_y_o,
  output logic          line_start_o,
  output logic          frame_start_o
`ifdef VGA_FRAME_COUNTER_EN
  ,
  output logic [7:0]    frame_cnt_o
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END = XW'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END = YW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = (H_POL != 0);
  localparam logic VS_ON = (V_POL != 0);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h
    $error("vga_timing_gen: horizontal porch/sync widths must be >= 1");
  end
  if (V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v
    $error("vga_timing_gen: vertical porch/sync widths must be >= 1");
  end
  if (H_TOTAL - 1 >= (1 << XW)) begin : g_bad_xw
    $error("vga_timing_gen: XW too narrow for H_TOTAL-1");
  end
  if (V_TOTAL - 1 >= (1 << YW)) begin : g_bad_yw
    $error("vga_timing_gen: YW too narrow for V_TOTAL-1");
  end

  logic [DW-1:0] div_q, div_d;
  // wrap_q remembers that the divider sits on its last count. It survives a
  // disable window so the pending pixel advance is not lost on re-enable.
  logic          wrap_q, wrap_d;
  logic [XW-1:0] h_q, h_d;
  logic [YW-1:0] v_q, v_d;
  logic          tick_q, tick_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          von_q, von_d;
  logic          ls_q, ls_d;
  logic          fs_q, fs_d;
  logic          adv;

  always_comb begin
    div_d  = div_q;
    wrap_d = wrap_q;
    h_d    = h_q;
    v_d    = v_q;
    adv    = 1'b0;
    if (enable_i) begin
      adv    = wrap_q;
      div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      wrap_d = (div_d == DIV_LAST);
      if (adv) begin
        if (h_q == H_LAST) begin
          h_d = '0;
          v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
          h_d = h_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    tick_d = enable_i & wrap_d;
    hs_d   = hs_q;
    vs_d   = vs_q;
    if (enable_i) begin
      hs_d = (h_d >= HS_BEG && h_d < HS_END) ? HS_ON : ~HS_ON;
      vs_d = (v_d >= VS_BEG && v_d < VS_END) ? VS_ON : ~VS_ON;
    end
    von_d = enable_i & (h_d < H_ACT) & (v_d < V_ACT);
    ls_d  = adv & (h_d == '0);
    fs_d  = ls_d & (v_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q  <= '0;
      wrap_q <= 1'b0;
      h_q    <= '0;
      v_q    <= '0;
      tick_q <= 1'b0;
      hs_q   <= ~HS_ON;
      vs_q   <= ~VS_ON;
      von_q  <= 1'b0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      wrap_q <= wrap_d;
      h_q    <= h_d;
      v_q    <= v_d;
      tick_q <= tick_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      von_q  <= von_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
    end
  end

  assign pixel_tick_o  = tick_q;
  assign hsync_o       = hs_q;
  assign vsync_o       = vs_q;
  assign video_on_o    = von_q;
  assign pixel_x_o     = h_q;
  assign pixel_y_o     = v_q;
  assign line_start_o  = ls_q;
  assign frame_start_o = fs_q;

`ifdef VGA_FRAME_COUNTER_EN
  logic [7:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    if (fs_d) begin
      fcnt_d = fcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign frame_cnt_o = fcnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance and a
// small 12x7 instance (CLK_DIV=1, H_POL=1) share one clock.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic       rst_d, en_d, rst_s, en_s;
  logic       d_tick, d_hs, d_vs, d_von, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_tick, s_hs, s_vs, s_von, s_ls, s_fs;
  logic [9:0] s_x, s_y;
`ifdef VGA_FRAME_COUNTER_EN
  logic [7:0] d_cnt, s_cnt;
`endif

  vga_timing_gen u_def (
    .clk_i         (clk),
    .reset_i       (rst_d),
    .enable_i      (en_d),
    .pixel_tick_o  (d_tick),
    .hsync_o       (d_hs),
    .vsync_o       (d_vs),
    .video_on_o    (d_von),
    .pixel_x_o     (d_x),
    .pixel_y_o     (d_y),
    .line_start_o  (d_ls),
    .frame_start_o (d_fs)
`ifdef VGA_FRAME_COUNTER_EN
    ,
    .frame_cnt_o   (d_cnt)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .H_POL (1), .V_POL (0), .CLK_DIV (1)
  ) u_small (
    .clk_i         (clk),
    .reset_i       (rst_s),
    .enable_i      (en_s),
    .pixel_tick_o  (s_tick),
    .hsync_o       (s_hs),
    .vsync_o       (s_vs),
    .video_on_o    (s_von),
    .pixel_x_o     (s_x),
    .pixel_y_o     (s_y),
    .line_start_o  (s_ls),
    .frame_start_o (s_fs)
`ifdef VGA_FRAME_COUNTER_EN
    ,
    .frame_cnt_o   (s_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get(input int sel);
    case (sel)
      0: get = 32'(d_x);
      1: get = 32'(d_ls);
      2: get = 32'(d_hs);
      3: get = 32'(s_fs);
      4: get = 32'(s_x);
      5: get = 32'(s_y);
      default: get = 32'(d_y);
    endcase
  endfunction

  task automatic wait_until(input string tag, input int sel,
                            input int val, input int lim);
    int n;
    n = 0;
    while (get(sel) !== 32'(val) && n < lim) begin
      step();
      n++;
    end
    check(tag, get(sel), 32'(val));
  endtask

  initial begin
    int t0, t1, cnt;
    rst_d = 1'b1; en_d = 1'b1;
    rst_s = 1'b1; en_s = 1'b1;
    step(); step();
    check("rst_x", 32'(d_x), 0);
    check("rst_y", 32'(d_y), 0);
    check("rst_hs", 32'(d_hs), 1);
    check("rst_vs", 32'(d_vs), 1);
    check("rst_von", 32'(d_von), 0);
    check("rst_tick", 32'(d_tick), 0);
    check("rst_ls", 32'(d_ls), 0);
    check("rst_fs", 32'(d_fs), 0);

    rst_d = 1'b0;
    repeat (400) step();
    check("mid_x", 32'(d_x), 100);
    check("mid_von", 32'(d_von), 1);
    rst_d = 1'b1;
    step();
    check("midrst_x", 32'(d_x), 0);
    check("midrst_hs", 32'(d_hs), 1);
    check("midrst_vs", 32'(d_vs), 1);
    check("midrst_von", 32'(d_von), 0);
    check("midrst_tick", 32'(d_tick), 0);

    rst_d = 1'b0;
    step();
    check("rel_von", 32'(d_von), 1);
    check("rel_x", 32'(d_x), 0);
    check("rel_tick", 32'(d_tick), 0);
    check("rel_ls", 32'(d_ls), 0);
    check("rel_hs", 32'(d_hs), 1);
    step(); step();
    check("tick_e3", 32'(d_tick), 1);
    check("x_e3", 32'(d_x), 0);
    step();
    check("tick_e4", 32'(d_tick), 0);
    check("x_e4", 32'(d_x), 1);
    repeat (3) step();
    check("tick_e7", 32'(d_tick), 1);
    step();
    check("tick_e8", 32'(d_tick), 0);
    check("x_e8", 32'(d_x), 2);

    wait_until("ls1_wait", 1, 1, 4000);
    t0 = cyc;
    check("ls1_x", 32'(d_x), 0);
    check("ls1_y", 32'(d_y), 1);
    check("ls1_fs", 32'(d_fs), 0);
    step();
    check("ls_width", 32'(d_ls), 0);
    wait_until("ls2_wait", 1, 1, 4000);
    check("line_period", 32'(cyc - t0), 3200);

    wait_until("x639_wait", 0, 639, 4000);
    check("von_639", 32'(d_von), 1);
    check("hs_639", 32'(d_hs), 1);
    wait_until("x640_wait", 0, 640, 20);
    check("von_640", 32'(d_von), 0);
    check("hs_640", 32'(d_hs), 1);
    wait_until("hs_fall", 2, 0, 200);
    check("hs_start_x", 32'(d_x), 656);
    cnt = 0;
    while (d_hs === 1'b0 && cnt < 1000) begin
      cnt++;
      step();
    end
    check("hs_low_clks", 32'(cnt), 384);
    check("hs_end_x", 32'(d_x), 752);
    check("vs_line2", 32'(d_vs), 1);

    wait_until("ls3_wait", 1, 1, 4000);
    t0 = cyc;
    wait_until("x300_wait", 0, 300, 2000);
    t1 = cyc;
    en_d = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_x", 32'(d_x), 300);
      check("hold_von", 32'(d_von), 0);
      check("hold_tick", 32'(d_tick), 0);
    end
    en_d = 1'b1;
    step();
    check("reen_von", 32'(d_von), 1);
    check("reen_x", 32'(d_x), 300);
    wait_until("x301_wait", 0, 301, 20);
    check("resume_time", 32'(cyc - t1), 14);
    wait_until("ls4_wait", 1, 1, 4000);
    check("line_period_stall", 32'(cyc - t0), 3210);

    rst_s = 1'b1;
    step();
    check("s_rst_hs", 32'(s_hs), 0);
    check("s_rst_vs", 32'(s_vs), 1);
    check("s_rst_von", 32'(s_von), 0);
    rst_s = 1'b0;
    step();
    check("s_rel_x", 32'(s_x), 0);
    check("s_rel_tick", 32'(s_tick), 1);
    check("s_rel_von", 32'(s_von), 1);
    step();
    check("s_e2_x", 32'(s_x), 1);
    wait_until("s_x8_wait", 4, 8, 20);
    check("s_hs_8", 32'(s_hs), 0);
    check("s_von_8", 32'(s_von), 0);
    step();
    check("s_x9", 32'(s_x), 9);
    check("s_hs_9", 32'(s_hs), 1);
    step();
    check("s_hs_10", 32'(s_hs), 1);
    step();
    check("s_hs_11", 32'(s_hs), 0);
    step();
    check("s_wrap_x", 32'(s_x), 0);
    check("s_wrap_ls", 32'(s_ls), 1);
    check("s_wrap_y", 32'(s_y), 1);
    check("s_wrap_fs", 32'(s_fs), 0);

    wait_until("s_fs1_wait", 3, 1, 200);
    t0 = cyc;
    check("s_fs_x", 32'(s_x), 0);
    check("s_fs_y", 32'(s_y), 0);
    step();
    check("s_fs_width", 32'(s_fs), 0);
    wait_until("s_fs2_wait", 3, 1, 200);
    check("s_frame_period", 32'(cyc - t0), 84);

    wait_until("s_y4_wait", 5, 4, 100);
    check("s_vs_4", 32'(s_vs), 1);
    check("s_von_y4", 32'(s_von), 0);
    wait_until("s_y5_wait", 5, 5, 100);
    check("s_vs_5", 32'(s_vs), 0);
    wait_until("s_y6_wait", 5, 6, 100);
    check("s_vs_6", 32'(s_vs), 1);

`ifdef VGA_FRAME_COUNTER_EN
    rst_s = 1'b1;
    step();
    check("cnt_rst", 32'(s_cnt), 0);
    rst_s = 1'b0;
    for (int k = 1; k <= 260; k++) begin
      wait_until("cnt_fs_wait", 3, 1, 200);
      if (k == 255) check("cnt_255", 32'(s_cnt), 255);
      if (k == 256) check("cnt_wrap", 32'(s_cnt), 0);
      step();
    end
    check("cnt_end", 32'(s_cnt), 4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 sync generator in the VGA path.
- Generates hsync/vsync, video_on, pixel coordinates and line/frame strobes for any resolution and porch set.
- Contains an internal pixel-clock-enable divider, so it runs directly on the board clock instead of a derived 25 MHz clock.
- Sits between the system clock and the colour/pixel logic; replaces the separate clock divider plus sync pair.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)
- CLK_DIV, 4, system clocks per pixel (>=1)
- XW, 10, pixel_x_o width; must hold H_TOTAL-1
- YW, 10, pixel_y_o width; must hold V_TOTAL-1

Ports:
- clk_i  input  1  system clock
- reset_i  input  1  synchronous, active-high reset
- enable_i  input  1  run enable; low freezes timing
- pixel_tick_o  output  1  one-clk pixel enable, once per CLK_DIV clks
- hsync_o  output  1  horizontal sync, polarity per H_POL
- vsync_o  output  1  vertical sync, polarity per V_POL
- video_on_o  output  1  high inside the active area
- pixel_x_o  output  XW  horizontal counter
- pixel_y_o  output  YW  vertical counter
- line_start_o  output  1  one-clk pulse when h wraps to 0
- frame_start_o  output  1  one-clk pulse when h and v both wrap to 0

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Reset values (while reset_i high at an edge):
  - div counter 0, h 0, v 0
  - pixel_tick_o 0, line_start_o 0, frame_start_o 0, video_on_o 0
  - hsync_o = !H_POL, vsync_o = !V_POL
  - Reset has priority over enable_i and takes effect mid-frame with no drain.
- Divider:
  - Counts 0..CLK_DIV-1 while enable_i=1.
  - pixel_tick_o is registered and is high exactly for the clk in which the divider value is CLK_DIV-1.
  - CLK_DIV=1: pixel_tick_o is high every enabled clk.
- Counter advance on an edge where pixel_tick_o=1 and enable_i=1:
  - h increments; at H_TOTAL-1 it wraps to 0 and v increments.
  - v wraps from V_TOTAL-1 to 0 when h wraps.
- Decode, registered from next-state values so outputs stay aligned with pixel_x_o/pixel_y_o (zero skew, no combinational path to pins):
  - hsync active iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync active iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
  - video_on iff h < H_ACTIVE and v < V_ACTIVE.
- line_start_o: high for the single clk after the edge on which h became 0. frame_start_o: same, when h=0 and v=0 together. Both last one clk, not CLK_DIV clks.
- After reset release: decode of (0,0) appears from the first edge, i.e. video_on_o=1 and both syncs inactive. No line_start_o/frame_start_o pulse until the first wrap.
- enable_i=0:
  - Divider, h and v hold.
  - pixel_tick_o, line_start_o, frame_start_o are 0.
  - video_on_o is forced 0; syncs hold their value.
- Re-enable: resumes from the held counts with no skipped or repeated pixel.
- Parameter check: elaboration error if CLK_DIV<1, any porch/sync width <1, or XW/YW too narrow.

Optional Feature:
- Macro: VGA_FRAME_COUNTER_EN.
- Defined: adds output frame_cnt_o, 8 bits.
  - Reset value 0.
  - Increments modulo 256 on the same edge that sets frame_start_o; holds while enable_i=0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset during mid-line with defaults -> next clk h=0, v=0, hsync_o=1, vsync_o=1, video_on_o=0; one clk after release video_on_o=1.
- Defaults, CLK_DIV=4 -> pixel_tick_o period 4 clks; line_start_o period 3200 clks; frame_start_o period 1,680,000 clks; hsync_o low for exactly 384 clks starting when h=656.
- Defaults -> vsync_o low only for v=490..491; video_on_o low for h>=640 or v>=480; no skew versus pixel_x_o/pixel_y_o.
- Small config H 8/1/2/1, V 4/1/1/1, CLK_DIV=1, H_POL=1 -> H_TOTAL 12, frame_start_o every 84 clks, hsync_o high at h=9..10.
- Drop enable_i for 10 clks at h=300 -> h holds 300, video_on_o=0, no ticks; after re-enable next value 301 and line period extends by exactly 10 clks.
- With VGA_FRAME_COUNTER_EN, small config, 260 frames -> frame_cnt_o wraps 255->0 and reads 4 at the end.
